ff_drive_ctrl: RTL and testbench
================================

Name: ff_drive_ctrl

Overview:
- Digital stimulus and capture sequencer that drives the data and complementary clock inputs of a master-slave flip-flop under test (D, CK, CKB), then reads back its Q output.
- Serialises a latched bit pattern onto FF_D, generates one FF clock pulse per bit, samples FF_Q, and compares the result against the expected bit.
- Sits beside the neuron storage cells as the drive/readback end of the flip-flop interface.
- Used for functional, timing and power characterisation runs.

Parameters:
- PAT_W, 8, pattern length in bits (max bits per run), >=1
- LOW_CYC, 2, CK cycles per FF clock low phase (FF_D setup window), >=1
- HIGH_CYC, 2, CK cycles per FF clock high phase (clk-to-Q settle window), >=1
- ERR_W, 4, error counter width

Ports:
- CK  input  1  system clock; all state changes on its rising edge
- RSTB  input  1  reset, synchronous, active-low
- START  input  1  run request, sampled only in IDLE
- PATTERN  input  PAT_W  bits to apply, bit 0 first
- NBITS  input  $clog2(PAT_W+1)  number of bits to apply; values above PAT_W are clamped to PAT_W
- FF_Q  input  1  digitised Q of the flip-flop under test
- FF_D  output  1  data to the flip-flop under test
- FF_CK  output  1  true clock to the flip-flop under test
- FF_CKB  output  1  complement clock; always equal to ~FF_CK
- BUSY  output  1  high from the cycle after START acceptance until DONE
- DONE  output  1  one-cycle pulse at end of run
- CAPTURE  output  PAT_W  sampled FF_Q values; bit i holds the sample for bit i
- ERR_CNT  output  ERR_W  mismatches in the last run, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is CK, reset port is RSTB.
- Reset (RSTB=0 at a CK edge), including mid-run: state=IDLE, FF_D=0, FF_CK=0, FF_CKB=1, BUSY=0, DONE=0, CAPTURE=0, ERR_CNT=0. Any run in progress is abandoned with no DONE.
- All outputs are registered. FF_CK and FF_CKB update in the same register stage and are never equal.
- States:
  - IDLE: FF_CK=0. When START=1, latch PATTERN and clamped NBITS, clear CAPTURE and ERR_CNT, and go to LOW with idx=0. If the latched NBITS is 0, go to DONE instead.
  - LOW: FF_D=PATTERN[idx] from the first LOW cycle, FF_CK=0, held for LOW_CYC cycles, then go to HIGH.
  - HIGH: FF_CK=1, FF_D held, for HIGH_CYC cycles. On the last HIGH cycle, sample FF_Q into CAPTURE[idx]. If FF_Q != PATTERN[idx], increment ERR_CNT, saturating at 2^ERR_W-1. Then:
    - if idx==NBITS-1, go to DONE;
    - otherwise idx++ and go to LOW.
  - DONE: FF_CK=0, DONE=1 for exactly one cycle, BUSY=0, then go to IDLE. CAPTURE and ERR_CNT hold until the next accepted START.
- Latency: DONE asserts 1+NBITS*(LOW_CYC+HIGH_CYC) cycles after the START-accept edge (1 cycle for NBITS=0).
- START while BUSY or DONE is ignored; the latched PATTERN/NBITS do not change mid-run.
- START held high continuously starts a new run on the first IDLE cycle after DONE.
- FF_D changes only at LOW entry, never while FF_CK=1.
- FF_Q is sampled only in the last HIGH cycle; FF_Q activity at other times has no effect.

Test Plan:
- Defaults; PATTERN=8'b1011_0010, NBITS=8, FF_Q looped from a behavioural DFF on FF_CK rise -> DONE 33 cycles after START, CAPTURE=8'hB2, ERR_CNT=0, FF_CKB==~FF_CK on every cycle.
- Same run with FF_Q tied 0 -> CAPTURE=0, ERR_CNT=4. With ERR_W=2 and PATTERN=8'hFF -> ERR_CNT saturates at 3.
- NBITS=0 -> BUSY never high, DONE one cycle after START, no FF_CK pulse. NBITS=12 -> clamped to 8, DONE after 33 cycles.
- START pulsed again at cycle 10 of a run with PATTERN changed to 8'h00 -> ignored; CAPTURE still 8'hB2. START held high -> second run begins the cycle after DONE.
- RSTB=0 for one cycle mid-HIGH of bit 3 -> next cycle FF_CK=0, FF_CKB=1, FF_D=0, BUSY=0, CAPTURE=0, ERR_CNT=0, no DONE pulse. A subsequent START runs cleanly.
- LOW_CYC=1, HIGH_CYC=3, NBITS=2 -> FF_CK high exactly 3 cycles per pulse, FF_D stable across each high phase, DONE at cycle 9.

Source files
------------

// File: rtl/ff_drive_ctrl.sv
// Drive/readback sequencer for a master-slave flip-flop under test:
// serialises a pattern onto FF_D, pulses FF_CK/FF_CKB per bit, captures FF_Q.
module ff_drive_ctrl #(
  parameter int PAT_W    = 8,
  parameter int LOW_CYC  = 2,
  parameter int HIGH_CYC = 2,
  parameter int ERR_W    = 4
) (
  input  logic                       CK,
  input  logic                       RSTB,
  input  logic                       START,
  input  logic [PAT_W-1:0]           PATTERN,
  input  logic [$clog2(PAT_W+1)-1:0] NBITS,
  input  logic                       FF_Q,
  output logic                       FF_D,
  output logic                       FF_CK,
  output logic                       FF_CKB,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [PAT_W-1:0]           CAPTURE,
  output logic [ERR_W-1:0]           ERR_CNT
);

  localparam int NB_W = $clog2(PAT_W + 1);
  localparam int IW   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int CMAX = (LOW_CYC > HIGH_CYC) ? LOW_CYC : HIGH_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d, idx_nxt;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] cap_q, cap_d;
  logic [NB_W-1:0]  nb_q, nb_d, nb_clamp;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ffd_q, ffd_d;
  logic             ck_q, ckb_q, busy_q, done_q;
  logic             low_end, high_end, last_bit;

  assign nb_clamp = (NBITS > NB_W'(PAT_W)) ? NB_W'(PAT_W) : NBITS;
  assign low_end  = (cnt_q == CW'(LOW_CYC - 1));
  assign high_end = (cnt_q == CW'(HIGH_CYC - 1));
  assign idx_nxt  = idx_q + 1'b1;
  assign last_bit = ((int'(idx_q) + 1) == int'(nb_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    nb_d    = nb_q;
    cap_d   = cap_q;
    err_d   = err_q;
    ffd_d   = ffd_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          pat_d = PATTERN;
          nb_d  = nb_clamp;
          cap_d = '0;
          err_d = '0;
          idx_d = '0;
          cnt_d = '0;
          if (nb_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOW;
            ffd_d   = PATTERN[0];
          end
        end
      end
      S_LOW: begin
        if (low_end) begin
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (high_end) begin
          cnt_d        = '0;
          cap_d[idx_q] = FF_Q;
          // error count sticks at all-ones
          if ((FF_Q != pat_q[idx_q]) && (err_q != '1))
            err_d = err_q + 1'b1;
          if (last_bit) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_nxt;
            ffd_d   = pat_q[idx_nxt];
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RSTB) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      nb_q    <= '0;
      cap_q   <= '0;
      err_q   <= '0;
      ffd_q   <= 1'b0;
      ck_q    <= 1'b0;
      ckb_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      nb_q    <= nb_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
      ffd_q   <= ffd_d;
      ck_q    <= (state_d == S_HIGH);
      ckb_q   <= (state_d != S_HIGH);
      busy_q  <= (state_d == S_LOW) || (state_d == S_HIGH);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign FF_D    = ffd_q;
  assign FF_CK   = ck_q;
  assign FF_CKB  = ckb_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign CAPTURE = cap_q;
  assign ERR_CNT = err_q;

endmodule

// File: tb/tb_ff_drive_ctrl.sv
// Bench for ff_drive_ctrl: three parameterisations against a
// run-offset model plus directed literal expectations.
module tb_ff_drive_ctrl;

  logic       CK = 1'b0;
  logic       RSTB, START, tie0;
  logic [7:0] PATTERN;
  logic [3:0] NBITS;

  logic [2:0] o_d, o_ck, o_ckb, o_busy, o_done;
  logic [7:0] o_cap [3];
  logic [3:0] o_err [3];
  logic [3:0] e0, e2;
  logic [1:0] e1;
  logic       dff0 = 1'b0;
  logic       dff2 = 1'b0;
  logic       q0;
  logic       q1 = 1'b0;
  logic [2:0] qv;

  int  checks   = 0;
  int  failures = 0;
  bit  chk_en   = 1'b0;

  assign q0       = tie0 ? 1'b0 : dff0;
  assign qv       = {dff2, q1, q0};
  assign o_err[0] = e0;
  assign o_err[1] = {2'b00, e1};
  assign o_err[2] = e2;

  always #5 CK = ~CK;

  ff_drive_ctrl u0 (
    .CK(CK), .RSTB(RSTB), .START(START),
    .PATTERN(PATTERN), .NBITS(NBITS), .FF_Q(q0),
    .FF_D(o_d[0]), .FF_CK(o_ck[0]), .FF_CKB(o_ckb[0]),
    .BUSY(o_busy[0]), .DONE(o_done[0]),
    .CAPTURE(o_cap[0]), .ERR_CNT(e0)
  );

  ff_drive_ctrl #(.ERR_W(2)) u1 (
    .CK(CK), .RSTB(RSTB), .START(START),
    .PATTERN(PATTERN), .NBITS(NBITS), .FF_Q(q1),
    .FF_D(o_d[1]), .FF_CK(o_ck[1]), .FF_CKB(o_ckb[1]),
    .BUSY(o_busy[1]), .DONE(o_done[1]),
    .CAPTURE(o_cap[1]), .ERR_CNT(e1)
  );

  ff_drive_ctrl #(.LOW_CYC(1), .HIGH_CYC(3)) u2 (
    .CK(CK), .RSTB(RSTB), .START(START),
    .PATTERN(PATTERN), .NBITS(NBITS), .FF_Q(dff2),
    .FF_D(o_d[2]), .FF_CK(o_ck[2]), .FF_CKB(o_ckb[2]),
    .BUSY(o_busy[2]), .DONE(o_done[2]),
    .CAPTURE(o_cap[2]), .ERR_CNT(e2)
  );

  // behavioural flip-flops under test
  always @(posedge o_ck[0]) dff0 <= o_d[0];
  always @(posedge o_ck[2]) dff2 <= o_d[2];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // model: mt = cycle number within the current run (0 = idle)
  int         lcy  [3] = '{2, 2, 1};
  int         pcy  [3] = '{4, 4, 4};
  int         emax [3] = '{15, 3, 15};
  int         mt   [3];
  int         mT   [3];
  int         merr [3];
  logic [7:0] mpat [3];
  logic [7:0] mcap [3];
  logic       mffd [3];

  always @(posedge CK) begin
    for (int i = 0; i < 3; i++) begin
      int k;
      int n;
      if (!RSTB) begin
        mt[i] = 0; mT[i] = 0; merr[i] = 0;
        mcap[i] = 8'h00; mffd[i] = 1'b0;
      end else if (mt[i] == 0) begin
        if (START) begin
          n = (int'(NBITS) > 8) ? 8 : int'(NBITS);
          mpat[i] = PATTERN;
          mT[i]   = n * pcy[i];
          mcap[i] = 8'h00;
          merr[i] = 0;
          mt[i]   = 1;
        end
      end else if (mt[i] == mT[i] + 1) begin
        mt[i] = 0;
      end else begin
        if (mt[i] % pcy[i] == 0) begin
          k = mt[i] / pcy[i] - 1;
          mcap[i][k] = qv[i];
          if (qv[i] != mpat[i][k] && merr[i] < emax[i])
            merr[i]++;
        end
        mt[i]++;
      end
      if (mt[i] >= 1 && mt[i] <= mT[i])
        mffd[i] = mpat[i][(mt[i] - 1) / pcy[i]];
    end
  end

  function automatic bit e_busy(int i);
    return (mt[i] >= 1) && (mt[i] <= mT[i]);
  endfunction

  function automatic bit e_ck(int i);
    return e_busy(i) && (((mt[i] - 1) % pcy[i]) >= lcy[i]);
  endfunction

  function automatic bit e_done(int i);
    return (mt[i] != 0) && (mt[i] == mT[i] + 1);
  endfunction

  always @(negedge CK) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("ck%0d", i), o_ck[i], e_ck(i));
        chk($sformatf("ckb%0d", i), o_ckb[i], !e_ck(i));
        chk($sformatf("d%0d", i), o_d[i], mffd[i]);
        chk($sformatf("busy%0d", i), o_busy[i], e_busy(i));
        chk($sformatf("done%0d", i), o_done[i], e_done(i));
        chk($sformatf("cap%0d", i), o_cap[i], mcap[i]);
        chk($sformatf("err%0d", i), o_err[i], merr[i]);
      end
    end
  end

  int dc [3];
  int hcnt [3];
  int bcnt [3];

  task automatic wait_done(input int poke, input bit hold,
                           output int c);
    c = 0;
    for (int i = 0; i < 3; i++) begin
      dc[i] = 0; hcnt[i] = 0; bcnt[i] = 0;
    end
    while (c < 300) begin
      @(negedge CK);
      c++;
      if (!hold && c == 1) START = 1'b0;
      if (c == poke) begin
        START = 1'b1;
        PATTERN = 8'h00;
      end
      if (c == poke + 1) START = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (o_ck[i]) hcnt[i]++;
        if (o_busy[i]) bcnt[i]++;
        if (o_done[i] && dc[i] == 0) dc[i] = c;
      end
      if (o_done[0]) break;
    end
    chk("done_seen", o_done[0], 1);
  endtask

  task automatic go(input logic [7:0] p, input logic [3:0] n,
                    input int poke, input bit hold, output int c);
    @(negedge CK);
    PATTERN = p;
    NBITS   = n;
    START   = 1'b1;
    wait_done(poke, hold, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int nd;
    RSTB = 1'b0; START = 1'b0; tie0 = 1'b0;
    PATTERN = 8'h00; NBITS = 4'd0;
    repeat (3) @(negedge CK);
    chk("rst_ck", o_ck[0], 0);
    chk("rst_ckb", o_ckb[0], 1);
    chk("rst_busy", o_busy[0], 0);
    chk("rst_done", o_done[0], 0);
    chk("rst_cap", o_cap[0], 0);
    RSTB = 1'b1;
    chk_en = 1'b1;

    go(8'hB2, 4'd8, -1, 1'b0, c);
    chk("t1_lat", c, 33);
    chk("t1_cap0", o_cap[0], 8'hB2);
    chk("t1_err0", o_err[0], 0);
    chk("t1_err1_sat", o_err[1], 3);
    chk("t1_cap2", o_cap[2], 8'hB2);
    chk("t1_hi0", hcnt[0], 16);
    chk("t1_dc2", dc[2], 33);

    tie0 = 1'b1;
    go(8'hB2, 4'd8, -1, 1'b0, c);
    chk("t2_cap0", o_cap[0], 0);
    chk("t2_err0", o_err[0], 4);
    tie0 = 1'b0;

    go(8'hFF, 4'd8, -1, 1'b0, c);
    chk("t3_err1_sat", o_err[1], 3);
    chk("t3_cap0", o_cap[0], 8'hFF);

    go(8'h5A, 4'd0, -1, 1'b0, c);
    chk("t4_lat", c, 1);
    chk("t4_hi0", hcnt[0], 0);
    chk("t4_busy0", bcnt[0], 0);
    chk("t4_cap0", o_cap[0], 0);

    go(8'hB2, 4'd12, -1, 1'b0, c);
    chk("t5_lat", c, 33);
    chk("t5_cap0", o_cap[0], 8'hB2);

    go(8'hB2, 4'd8, 10, 1'b0, c);
    chk("t6_lat", c, 33);
    chk("t6_cap0", o_cap[0], 8'hB2);

    go(8'hB2, 4'd8, -1, 1'b1, c);
    chk("t7_lat", c, 33);
    @(negedge CK);
    chk("t7_idle_busy", o_busy[0], 0);
    @(negedge CK);
    chk("t7_rerun_busy", o_busy[0], 1);
    START = 1'b0;
    wait_done(-1, 1'b0, c);
    chk("t7_lat2", c, 32);

    @(negedge CK);
    PATTERN = 8'hBA; NBITS = 4'd8; START = 1'b1;
    c = 0;
    repeat (15) begin
      @(negedge CK);
      c++;
      if (c == 1) START = 1'b0;
    end
    chk("t8_pre_ck", o_ck[0], 1);
    chk("t8_pre_cap", o_cap[0], 8'h02);
    RSTB = 1'b0;
    @(negedge CK);
    RSTB = 1'b1;
    chk("t8_ck", o_ck[0], 0);
    chk("t8_ckb", o_ckb[0], 1);
    chk("t8_d", o_d[0], 0);
    chk("t8_busy", o_busy[0], 0);
    chk("t8_cap", o_cap[0], 0);
    chk("t8_err", o_err[0], 0);
    nd = 0;
    repeat (40) begin
      @(negedge CK);
      if (o_done[0]) nd++;
    end
    chk("t8_no_done", nd, 0);
    go(8'hB2, 4'd8, -1, 1'b0, c);
    chk("t8_lat", c, 33);
    chk("t8_cap0", o_cap[0], 8'hB2);

    go(8'h02, 4'd2, -1, 1'b0, c);
    chk("t9_lat0", c, 9);
    chk("t9_dc2", dc[2], 9);
    chk("t9_hi2", hcnt[2], 6);
    chk("t9_hi0", hcnt[0], 4);
    chk("t9_cap2", o_cap[2], 8'h02);

    @(negedge CK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
